// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control unit: fetch/decode/execute/memory/writeback sequencing,
// program counter, latched ALU flags and memory handshakes.
module cpu_ctrl_fsm #(
   parameter int unsigned PC_W    = 9,
   parameter logic [2:0]  ALU_ADD = 3'b010
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imemReq,
   output logic [PC_W-1:0] pc,
   input  logic [31:0]     imemData,
   input  logic            imemReady,
   output logic            dmemRdEn,
   output logic            dmemWrEn,
   input  logic            dmemReady,
   input  logic            cFlag,
   input  logic            nFlag,
   input  logic            vFlag,
   input  logic            zFlag,
   output logic [15:0]     immediate,
   output logic [4:0]      rfRdAdrx0,
   output logic [4:0]      rfRdAdrx1,
   output logic [4:0]      rfWrAdrx,
   output logic [2:0]      aluCtl,
   output logic            rfWriteEn,
   output logic            aluBusBSel,
   output logic            dmemResultSel,
   output logic            regDest,
   output logic            halted,
   output logic            illegal
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_HALT, C_ILL
   } class_t;

   state_t          state, state_nxt;
   logic [31:0]     ir, ir_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [3:0]      flags, flags_nxt;   // {C, N, V, Z}
   logic            illegal_nxt;
   class_t          cls;
   logic [2:0]      func;
   logic            taken;

   assign cls       = class_t'(ir[31:29]);
   assign func      = ir[28:26];
   assign immediate = ir[15:0];
   assign rfRdAdrx0 = ir[25:21];
   assign rfRdAdrx1 = ir[20:16];
   assign rfWrAdrx  = ir[15:11];
   assign halted    = (state == S_HALT);

   always_comb begin
      taken = 1'b0;
      case (func)
         3'b000:  taken = 1'b1;
         3'b001:  taken = flags[0];
         3'b010:  taken = !flags[0];
         3'b011:  taken = flags[2];
         3'b100:  taken = flags[3];
         3'b101:  taken = flags[1];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      ir_nxt      = ir;
      pc_nxt      = pc;
      flags_nxt   = flags;
      illegal_nxt = illegal;
      case (state)
         S_FETCH: begin
            if (imemReady) begin
               ir_nxt    = imemData;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            pc_nxt = pc + PC_W'(1);
            case (cls)
               C_NOP:   state_nxt = S_FETCH;
               C_HALT:  state_nxt = S_HALT;
               C_ILL: begin
                  state_nxt   = S_HALT;
                  illegal_nxt = 1'b1;
               end
               default: state_nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_RALU, C_IALU: begin
                  flags_nxt = {cFlag, nFlag, vFlag, zFlag};
                  state_nxt = S_WB;
               end
               C_LOAD, C_STORE: state_nxt = S_MEM;
               C_BRANCH: begin
                  // pc already points past the branch; offset is truncated and wraps
                  if (taken) pc_nxt = pc + ir[PC_W-1:0];
                  state_nxt = S_FETCH;
               end
               default: state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmemReady) state_nxt = (cls == C_LOAD) ? S_WB : S_FETCH;
         end
         S_WB:    state_nxt = S_FETCH;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      imemReq       = 1'b0;
      dmemRdEn      = 1'b0;
      dmemWrEn      = 1'b0;
      rfWriteEn     = 1'b0;
      aluCtl        = '0;
      aluBusBSel    = 1'b0;
      dmemResultSel = 1'b0;
      regDest       = 1'b0;
      case (state)
         S_FETCH: imemReq = 1'b1;
         S_EXEC, S_MEM, S_WB: begin
            // ALU controls stay put from EXEC through MEM/WB so results remain stable
            case (cls)
               C_RALU: aluCtl = func;
               C_IALU: begin
                  aluCtl     = func;
                  aluBusBSel = 1'b1;
               end
               C_LOAD, C_STORE: begin
                  aluCtl     = ALU_ADD;
                  aluBusBSel = 1'b1;
               end
               default: aluCtl = '0;
            endcase
            if (state == S_MEM) begin
               dmemRdEn = (cls == C_LOAD);
               dmemWrEn = (cls == C_STORE);
            end
            if (state == S_WB) begin
               rfWriteEn     = 1'b1;
               regDest       = (cls == C_RALU);
               dmemResultSel = (cls == C_LOAD);
            end
         end
         default: imemReq = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= '0;
         ir      <= '0;
         flags   <= '0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         ir      <= ir_nxt;
         flags   <= flags_nxt;
         illegal <= illegal_nxt;
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: an instruction-level model predicts fetch
// addresses, fetch-to-fetch timing, exec/memory/writeback controls.
module tb_cpu_ctrl_fsm;
   localparam int         PC_W    = 9;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam int         PC_MOD  = 1 << PC_W;

   logic            clk = 1'b0, rst = 1'b1;
   logic            imemReq, imemReady = 1'b0, dmemRdEn, dmemWrEn, dmemReady = 1'b0;
   logic [PC_W-1:0] pc;
   logic [31:0]     imemData = '0;
   logic            cFlag = 1'b0, nFlag = 1'b0, vFlag = 1'b0, zFlag = 1'b0;
   logic [15:0]     immediate;
   logic [4:0]      rfRdAdrx0, rfRdAdrx1, rfWrAdrx;
   logic [2:0]      aluCtl;
   logic            rfWriteEn, aluBusBSel, dmemResultSel, regDest, halted, illegal;

   cpu_ctrl_fsm #(.PC_W(PC_W), .ALU_ADD(ALU_ADD)) dut (
      .clk(clk), .rst(rst), .imemReq(imemReq), .pc(pc), .imemData(imemData),
      .imemReady(imemReady), .dmemRdEn(dmemRdEn), .dmemWrEn(dmemWrEn),
      .dmemReady(dmemReady), .cFlag(cFlag), .nFlag(nFlag), .vFlag(vFlag),
      .zFlag(zFlag), .immediate(immediate), .rfRdAdrx0(rfRdAdrx0),
      .rfRdAdrx1(rfRdAdrx1), .rfWrAdrx(rfWrAdrx), .aluCtl(aluCtl),
      .rfWriteEn(rfWriteEn), .aluBusBSel(aluBusBSel), .dmemResultSel(dmemResultSel),
      .regDest(regDest), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct { int pc; int gap; bit exv; int alu; int bsel; } fetch_t;
   typedef struct { int dest; int rdest; int rsel; bit ld; } wr_t;
   typedef struct { bit st; int rs0; int imm; } mem_t;

   fetch_t fq[$];
   wr_t    wq[$];
   mem_t   mq[$];
   logic [31:0] prog[$];
   int          pw[$], pd[$];
   logic [3:0]  pf[$];

   int checks = 0, errors = 0;
   int mpc, mflags, mpost;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] c, input logic [2:0] f,
                                      input logic [4:0] r0, input logic [4:0] r1,
                                      input logic [15:0] imm);
      return {c, f, r0, r1, imm};
   endfunction

   function automatic bit br_taken(input int f, input int fl);
      case (f)
         0: return 1'b1;
         1: return fl[0];
         2: return !fl[0];
         3: return fl[2];
         4: return fl[3];
         5: return fl[1];
         default: return 1'b0;
      endcase
   endfunction

   // Instruction-level model: each appended instruction yields its expected events.
   task automatic add(input logic [31:0] word, input int w, input int d, input logic [3:0] fl);
      fetch_t f;
      wr_t    r;
      mem_t   m;
      int     cls, fn, inc;
      cls = int'(word[31:29]);
      fn  = int'(word[28:26]);
      prog.push_back(word); pw.push_back(w); pd.push_back(d); pf.push_back(fl);
      f.pc = mpc; f.gap = 1 + w + mpost; f.exv = 1'b0; f.alu = 0; f.bsel = 0;
      m.st = 1'b0; m.rs0 = int'(word[25:21]); m.imm = int'(word[15:0]);
      inc = (mpc + 1) % PC_MOD;
      case (cls)
         0: begin mpost = 1; mpc = inc; end
         1, 2: begin
            f.exv = 1'b1; f.alu = fn; f.bsel = (cls == 2) ? 1 : 0;
            mflags = int'(fl);
            r.dest = (cls == 1) ? int'(word[15:11]) : int'(word[20:16]);
            r.rdest = (cls == 1) ? 1 : 0; r.rsel = 0; r.ld = 1'b0;
            wq.push_back(r);
            mpost = 3; mpc = inc;
         end
         3: begin
            f.exv = 1'b1; f.alu = int'(ALU_ADD); f.bsel = 1;
            mq.push_back(m);
            r.dest = int'(word[20:16]); r.rdest = 0; r.rsel = 1; r.ld = 1'b1;
            wq.push_back(r);
            mpost = 4 + d; mpc = inc;
         end
         4: begin
            f.exv = 1'b1; f.alu = int'(ALU_ADD); f.bsel = 1;
            m.st = 1'b1;
            mq.push_back(m);
            mpost = 3 + d; mpc = inc;
         end
         5: begin
            mpost = 2;
            if (br_taken(fn, mflags)) mpc = (inc + int'($signed(word[15:0]))) & (PC_MOD - 1);
            else mpc = inc;
         end
         default: mpost = 0;
      endcase
      fq.push_back(f);
   endtask

   // Memory/datapath responder: honours the planned wait counts, drives junk when idle.
   int fidx = 0, icnt = 0, dcnt = 0;
   always @(negedge clk) begin
      int cur;
      if (rst) begin
         imemReady = 1'b0; dmemReady = 1'b0;
         fidx = 0; icnt = 0; dcnt = 0;
         {cFlag, nFlag, vFlag, zFlag} = 4'($urandom);
      end else begin
         cur = fidx - 1;
         if (cur >= 0 && cur < prog.size() && (prog[cur][31:29] == 3'd1 || prog[cur][31:29] == 3'd2))
            {cFlag, nFlag, vFlag, zFlag} = pf[cur];
         else
            {cFlag, nFlag, vFlag, zFlag} = 4'($urandom);
         if ((dmemRdEn || dmemWrEn) && cur >= 0 && cur < prog.size()) begin
            dmemReady = (dcnt >= pd[cur]);
            dcnt = dmemReady ? 0 : dcnt + 1;
         end else begin
            dmemReady = 1'($urandom);
            dcnt = 0;
         end
         if (imemReq) begin
            if (fidx < prog.size()) begin
               imemData  = prog[fidx];
               imemReady = (icnt >= pw[fidx]);
            end else imemReady = 1'b0;
            if (imemReady) begin fidx++; icnt = 0; end
            else icnt++;
         end else begin
            imemReady = 1'($urandom);
            imemData  = $urandom;
            icnt = 0;
         end
      end
   end

   // Monitor: compares every observed DUT event against the head of its queue.
   int     since = 0;
   fetch_t cur_f;
   always @(negedge clk) begin
      fetch_t f;
      wr_t    r;
      mem_t   m;
      #1;
      if (rst) begin
         since = 0; cur_f.exv = 1'b0;
      end else begin
         since++;
         if (since == 2 && cur_f.exv) begin
            chk("exec_aluCtl", int'(aluCtl), cur_f.alu);
            chk("exec_bsel", int'(aluBusBSel), cur_f.bsel);
         end
         if (dmemRdEn || dmemWrEn) begin
            chk("mem_aluCtl", int'(aluCtl), int'(ALU_ADD));
            chk("mem_bsel", int'(aluBusBSel), 1);
            if (dmemReady) begin
               if (mq.size() == 0) chk("mem_unexpected", 1, 0);
               else begin
                  m = mq.pop_front();
                  chk("mem_wr", int'(dmemWrEn), int'(m.st));
                  chk("mem_rd", int'(dmemRdEn), int'(!m.st));
                  chk("mem_rs0", int'(rfRdAdrx0), m.rs0);
                  chk("mem_imm", int'(immediate), m.imm);
               end
            end
         end
         if (rfWriteEn) begin
            if (wq.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
               r = wq.pop_front();
               chk("wb_dest", regDest ? int'(rfWrAdrx) : int'(rfRdAdrx1), r.dest);
               chk("wb_regDest", int'(regDest), r.rdest);
               chk("wb_resultSel", int'(dmemResultSel), r.rsel);
               if (r.ld) begin
                  chk("wb_ld_aluCtl", int'(aluCtl), int'(ALU_ADD));
                  chk("wb_ld_bsel", int'(aluBusBSel), 1);
               end
            end
         end
         if (imemReq && imemReady) begin
            if (fq.size() == 0) chk("fetch_unexpected", 1, 0);
            else begin
               f = fq.pop_front();
               chk("fetch_pc", int'(pc), f.pc);
               chk("fetch_gap", since, f.gap);
               cur_f = f;
            end
            since = 0;
         end
      end
   end

   task automatic start();
      @(posedge clk); #2;
      rst = 1'b1;
      fq.delete(); wq.delete(); mq.delete();
      prog.delete(); pw.delete(); pd.delete(); pf.delete();
      mpc = 0; mflags = 0; mpost = 0;
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pc", int'(pc), 0);
      chk("rst_imemReq", int'(imemReq), 1);
      chk("rst_halted", int'(halted), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_enables", int'({rfWriteEn, dmemRdEn, dmemWrEn}), 0);
      rst = 1'b0;
   endtask

   task automatic wait_halt(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #2;
         if (halted) break;
      end
      chk("halt_reached", int'(halted), 1);
      chk("fetch_q_empty", fq.size(), 0);
      chk("wb_q_empty", wq.size(), 0);
      chk("mem_q_empty", mq.size(), 0);
   endtask

   initial begin
      int imm;
      // Directed program: ALU ops, delayed load, conditional branches, store, pc wrap
      start();
      add(mk(3'd1, 3'd0, 5'd1, 5'd2, 16'(3 << 11)), 0, 0, 4'b0000);
      add(mk(3'd2, 3'd1, 5'd4, 5'd5, 16'h0007), 0, 0, 4'b0001);
      add(mk(3'd3, 3'd0, 5'd6, 5'd7, 16'd5), 0, 3, 4'b0000);
      add(mk(3'd0, 3'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 4'b0000);
      add(mk(3'd5, 3'd1, 5'd0, 5'd0, 16'hFFFE), 0, 0, 4'b0000);
      add(mk(3'd2, 3'd0, 5'd1, 5'd9, 16'h0001), 0, 0, 4'b1110);
      add(mk(3'd5, 3'd1, 5'd0, 5'd0, 16'hFFFE), 0, 0, 4'b0000);
      add(mk(3'd1, 3'd2, 5'd3, 5'd4, 16'(7 << 11)), 0, 0, 4'b0100);
      add(mk(3'd4, 3'd0, 5'd8, 5'd9, 16'h0010), 0, 0, 4'b0000);
      add(mk(3'd5, 3'd3, 5'd0, 5'd0, 16'h0002), 0, 0, 4'b0000);
      imm = (PC_MOD - 1) - (mpc + 1);
      add(mk(3'd5, 3'd0, 5'd0, 5'd0, 16'(imm)), 0, 0, 4'b0000);
      add(mk(3'd5, 3'd0, 5'd0, 5'd0, 16'h0001), 0, 0, 4'b0000);
      add(mk(3'd0, 3'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 4'b0000);
      add(mk(3'd6, 3'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 4'b0000);
      release_rst();
      wait_halt(500);
      chk("halt_not_illegal", int'(illegal), 0);

      // Reset while a load is stalled in MEM
      start();
      add(mk(3'd3, 3'd0, 5'd2, 5'd3, 16'h0004), 0, 100000, 4'b0000);
      release_rst();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #2;
         if (dmemRdEn) break;
      end
      chk("mem_wait_seen", int'(dmemRdEn), 1);
      rst = 1'b1;
      @(negedge clk); #2;
      chk("midmem_rdEn", int'(dmemRdEn), 0);
      chk("midmem_imemReq", int'(imemReq), 1);
      chk("midmem_pc", int'(pc), 0);

      // Illegal class halts and sticks until reset
      start();
      add(mk(3'd0, 3'd0, 5'd0, 5'd0, 16'h0000), 1, 0, 4'b0000);
      add(32'hE000_0000 | (32'($urandom) & 32'h1FFF_FFFF), 0, 0, 4'b0000);
      release_rst();
      wait_halt(200);
      chk("illegal_set", int'(illegal), 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #2;
         chk("halt_no_fetch", int'(imemReq), 0);
         chk("halt_held", int'(halted), 1);
      end

      // Random program with random memory latencies
      start();
      for (int i = 0; i < 120; i++) begin
         add(mk(3'($urandom_range(5, 0)), 3'($urandom), 5'($urandom), 5'($urandom), 16'($urandom)),
             int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 4'($urandom));
      end
      add(mk(3'd6, 3'd0, 5'd0, 5'd0, 16'h0000), 0, 0, 4'b0000);
      release_rst();
      wait_halt(5000);
      chk("rand_not_illegal", int'(illegal), 0);

      start();
      release_rst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit that fetches a 32-bit instruction, decodes it, and drives every control input of the CPU datapath (register-file addresses, ALU control, bus/result/destination selects, write enable) one phase at a time. It owns the program counter and the latched condition flags. It also handshakes with the instruction and data memories, stalling in place until each memory reports ready.

Parameters:
PC_W, 9, program counter width in words; wraps modulo 2^PC_W
ALU_ADD, 3'b010, aluCtl code that performs busA+busB; used for load/store address generation

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
imemReq  out  1  instruction fetch request
pc  out  PC_W  fetch address
imemData  in  32  instruction word
imemReady  in  1  imemData valid this cycle
dmemRdEn  out  1  data memory read request
dmemWrEn  out  1  data memory write request
dmemReady  in  1  data access complete; read data valid
cFlag, nFlag, vFlag, zFlag  in  1 each  ALU flags from datapath
immediate  out  16  IR[15:0]
rfRdAdrx0  out  5  IR[25:21]
rfRdAdrx1  out  5  IR[20:16]
rfWrAdrx  out  5  IR[15:11]
aluCtl  out  3  ALU operation
rfWriteEn  out  1  register write strobe
aluBusBSel  out  1  1=immediate, 0=rdData1
dmemResultSel  out  1  1=memory data, 0=ALU result
regDest  out  1  1=write rfWrAdrx, 0=write rfRdAdrx1
halted  out  1  core stopped
illegal  out  1  sticky: halted on class 111

Behaviour:
- Instruction layout: class=IR[31:29], func=IR[28:26]. Classes: 000 NOP, 001 R-ALU, 010 I-ALU, 011 LOAD, 100 STORE, 101 BRANCH, 110 HALT, 111 illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imemReq=1, held until imemReady. On the imemReady cycle, IR<=imemData, go to DECODE. Ready in the same cycle as the request is legal, giving a 1-cycle fetch.
- DECODE: pc<=pc+1. NOP goes to FETCH. HALT goes to HALT. Class 111 goes to HALT and sets illegal. All other classes go to EXEC.
- EXEC:
  - R-ALU: aluCtl=func, aluBusBSel=0.
  - I-ALU: aluCtl=func, aluBusBSel=1.
  - For both ALU classes, latch all four flags at the end of EXEC, then go to WB.
  - LOAD/STORE: aluCtl=ALU_ADD, aluBusBSel=1 (address = rs0+imm), go to MEM.
  - BRANCH: evaluate func against the latched flags: 000 always, 001 Z, 010 !Z, 011 N, 100 C, 101 V, 110/111 never. If taken, pc<=pc+imm[PC_W-1:0], with imm sign-truncated and the sum wrapping. The base is the already-incremented pc. Go to FETCH.
- MEM: hold EXEC's aluCtl/aluBusBSel so the address stays stable. Assert dmemRdEn (LOAD) or dmemWrEn (STORE) until dmemReady. On dmemReady, LOAD goes to WB and STORE goes to FETCH.
- WB: rfWriteEn=1 for exactly one cycle, then go to FETCH.
  - R-ALU: regDest=1, dmemResultSel=0.
  - I-ALU: regDest=0, dmemResultSel=0.
  - LOAD: regDest=0, dmemResultSel=1, aluCtl/aluBusBSel held.
- Flag latching: flags update only in EXEC of ALU classes; load, store and branch leave them unchanged.
- HALT: all enables 0, halted=1; stays until rst.
- Outputs: decoded combinationally from state+IR. rfWriteEn, dmemRdEn, dmemWrEn and imemReq are 0 in every state not listed above. The address outputs always reflect IR.
- Cycle counts with ready=1: NOP 2, BRANCH 3, R/I-ALU 4, STORE 4, LOAD 5.
- Reset: on a rst edge, state=FETCH, pc=0, IR=0, latched flags=0, halted=0, illegal=0, and all enables deassert the next cycle. This applies in every state, including mid-wait in MEM, in which case the pending memory access is abandoned. rst has priority over ready.

Test Plan:
- Reset, then imemReady=1 with R-ALU func=3'b000, rs0=1, rs1=2, rd=3 -> imemReq at pc=0; rfWriteEn high exactly in cycle 4 with regDest=1; pc=1.
- I-ALU, then LOAD with imm=5 and dmemReady delayed 3 cycles -> dmemRdEn high 4 cycles with aluCtl=ALU_ADD and aluBusBSel=1 throughout; WB has dmemResultSel=1 and regDest=0; LOAD takes 8 cycles total.
- Branches, one instruction per step:
  - ALU op with zFlag=1 latched, then BRANCH func=001 at pc=4 with imm=16'hFFFE -> next fetch pc=3.
  - Same branch with Z clear -> next fetch pc=5.
  - Branch at pc=511 with imm=1 -> pc wraps to 1.
- STORE, then flags driven changing during its EXEC, then BRANCH func=011 -> dmemWrEn only (no rfWriteEn); the branch uses the pre-store N flag.
- rst asserted in MEM while dmemReady=0 -> next cycle dmemRdEn=0, imemReq=1, pc=0.
- Class 111 word -> halted=1 and illegal=1 after DECODE; no further imemReq for 20 cycles; rst clears both.
